decod_bin_bcd_7seg: RTL and testbench

Sequential, parametrised binary-to-decimal display decoder. Converts an unsigned WIDTH-bit value to DIGITS BCD digits using iterative shift-add-3 (double dabble), one bit per clock, and drives DIGITS active-low seven-segment fields. It sits between the counter/arithmetic blocks and the board displays. It replaces fixed two-digit lookup decoders with a start/done handshake, an overflow indication and optional leading-zero blanking.

---
 rtl/decod_bin_bcd_7seg.sv | 141 ++++++++++++++
 tb/tb_decod_bin_bcd_7seg.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decod_bin_bcd_7seg.sv
// Sequential binary-to-BCD (double dabble, one bit per clock) with active-low 7-segment outputs.
// Optional leading-zero blanking is enabled by defining DECOD_BLANK_ZEROS_EN.
module decod_bin_bcd_7seg #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inicio,
    input  logic [WIDTH-1:0]      S,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  estouro,
    output logic [7*DIGITS-1:0]   saida_display,
    output logic [1:0]            estado
);

    // Handshake: inicio/S are taken on any rising edge outside CONV; inicio during CONV is dropped.
    // pronto is a one-cycle pulse in FIM; results hold until the next completion.
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CONV   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    localparam int          CW     = $clog2(WIDTH + 1);
    localparam int          BW     = 4 * DIGITS;
    localparam logic [31:0] LIMITE = 32'(10**DIGITS - 1);

    estado_t               estado_q, estado_d;
    logic [WIDTH-1:0]      bin_q, bin_nxt;
    logic [BW-1:0]         bcd_q, bcd_adj, bcd_nxt;
    logic [CW-1:0]         cnt_q;
    logic                  excede_q;
    logic [7*DIGITS-1:0]   disp_nxt;
    logic [3:0]            dig;
`ifdef DECOD_BLANK_ZEROS_EN
    logic                  zero_run;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO, FIM: estado_d = inicio ? CONV : OCIOSO;
            CONV:        if (cnt_q == CW'(1)) estado_d = FIM;
            default:     estado_d = OCIOSO;
        endcase
    end

    // One double-dabble step: correct nibbles >= 5, then shift the binary MSB into the BCD field.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        bcd_nxt = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
        bin_nxt = {bin_q[WIDTH-2:0], 1'b0};
    end

    // Display image of the final step, scanned from the most significant digit down.
    always_comb begin
        disp_nxt = '1;
        dig      = '0;
`ifdef DECOD_BLANK_ZEROS_EN
        zero_run = 1'b1;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dig = bcd_nxt[4*k +: 4];
            if (excede_q) begin
                disp_nxt[7*k +: 7] = 7'b1111110;
            end else begin
`ifdef DECOD_BLANK_ZEROS_EN
                if (zero_run && dig == 4'd0 && k != 0) begin
                    disp_nxt[7*k +: 7] = 7'b1111111;
                end else begin
                    zero_run           = 1'b0;
                    disp_nxt[7*k +: 7] = seg7(dig);
                end
`else
                disp_nxt[7*k +: 7] = seg7(dig);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= OCIOSO;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            excede_q      <= 1'b0;
            estouro       <= 1'b0;
            saida_display <= '1;
        end else begin
            estado_q <= estado_d;
            case (estado_q)
                OCIOSO, FIM: begin
                    if (inicio) begin
                        bin_q    <= S;
                        bcd_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        excede_q <= ({{(32-WIDTH){1'b0}}, S} > LIMITE);
                    end
                end
                CONV: begin
                    bin_q <= bin_nxt;
                    bcd_q <= bcd_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        saida_display <= disp_nxt;
                        estouro       <= excede_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado = (estado_q == CONV);
    assign pronto  = (estado_q == FIM);
    assign estado  = estado_q;

endmodule

// File: tb/tb_decod_bin_bcd_7seg.sv
// Self-checking bench for decod_bin_bcd_7seg: three instances (8/3, 8/2, 16/5) against a decimal model.
// Build with DECOD_BLANK_ZEROS_EN defined to check the leading-zero blanking variant.
module tb_decod_bin_bcd_7seg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic [7:0]  s8;
    logic        inicio16;
    logic [15:0] s16;

    logic        oc_a, pr_a, es_a;
    logic [20:0] disp_a;
    logic [1:0]  st_a;
    logic        oc_b, pr_b, es_b;
    logic [13:0] disp_b;
    logic [1:0]  st_b;
    logic        oc_c, pr_c, es_c;
    logic [34:0] disp_c;
    logic [1:0]  st_c;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];

    logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clk = ~clk;

    decod_bin_bcd_7seg #(.WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .S(s8),
        .ocupado(oc_a), .pronto(pr_a), .estouro(es_a), .saida_display(disp_a), .estado(st_a));

    decod_bin_bcd_7seg #(.WIDTH(8), .DIGITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .S(s8),
        .ocupado(oc_b), .pronto(pr_b), .estouro(es_b), .saida_display(disp_b), .estado(st_b));

    decod_bin_bcd_7seg #(.WIDTH(16), .DIGITS(5)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .inicio(inicio16), .S(s16),
        .ocupado(oc_c), .pronto(pr_c), .estouro(es_c), .saida_display(disp_c), .estado(st_c));

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal reference: digit k = (v / 10^k) % 10; dashes when v does not fit in d digits.
    function automatic logic [34:0] model_disp(input int v, input int d);
        logic [34:0] r = '1;
        for (int k = 0; k < d; k++) begin
            if (v > pow10(d) - 1)
                r[7*k +: 7] = 7'b1111110;
`ifdef DECOD_BLANK_ZEROS_EN
            else if (k > 0 && v < pow10(k))
                r[7*k +: 7] = 7'b1111111;
`endif
            else
                r[7*k +: 7] = seg_tab[(v / pow10(k)) % 10];
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int v, input int d);
        return v > pow10(d) - 1;
    endfunction

    task automatic start_conv8(input int v);
        @(negedge clk);
        inicio = 1'b1;
        s8     = 8'(v);
        @(posedge clk);
        #1;
        inicio = 1'b0;
        s8     = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset;
        rst_n = 1'b0; inicio = 1'b0; s8 = '0; inicio16 = 1'b0; s16 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (oc_a !== 1'b0 || pr_a !== 1'b0 || es_a !== 1'b0 || disp_a !== '1 ||
            oc_b !== 1'b0 || pr_b !== 1'b0 || es_b !== 1'b0 || disp_b !== '1 ||
            oc_c !== 1'b0 || pr_c !== 1'b0 || es_c !== 1'b0 || disp_c !== '1) begin
            errors++;
            $display("FAIL reset_values: oc=%b pr=%b es=%b disp_a=%h disp_b=%h disp_c=%h exp all-off idle",
                     oc_a, pr_a, es_a, disp_a, disp_b, disp_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (oc_a !== 1'b0 || pr_a !== 1'b0 || disp_a !== '1) begin
            errors++;
            $display("FAIL idle_after_reset: oc=%b pr=%b disp=%h exp 0 0 1fffff", oc_a, pr_a, disp_a);
        end
    endtask

    task automatic test_conversion;
        int vals[$] = '{255, 7, 0, 100, 99, 1, 10, 128, 200, 254};
        logic [34:0] mb;
        logic [20:0] exp_a;
        for (int i = 0; i < 12; i++) vals.push_back($urandom_range(0, 255));
        foreach (vals[i]) begin
            mb = model_disp(vals[i], 3);
            exp_q.push_back(mb[20:0]);
            start_conv8(vals[i]);
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (oc_a !== 1'b1 || pr_a !== 1'b0 || oc_b !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_phase v=%0d cyc=%0d: oc=%b pr=%b exp oc=1 pr=0", vals[i], c, oc_a, pr_a);
                end
                @(posedge clk);
                #1;
            end
            exp_a = exp_q.pop_front();
            mb    = model_disp(vals[i], 2);
            checks++;
            if (pr_a !== 1'b1 || oc_a !== 1'b0 || pr_b !== 1'b1) begin
                errors++;
                $display("FAIL done_pulse v=%0d: pr=%b oc=%b exp pr=1 oc=0", vals[i], pr_a, oc_a);
            end
            checks++;
            if (disp_a !== exp_a || es_a !== model_ovf(vals[i], 3)) begin
                errors++;
                $display("FAIL result_3dig v=%0d: disp=%b es=%b exp disp=%b es=%b",
                         vals[i], disp_a, es_a, exp_a, model_ovf(vals[i], 3));
            end
            checks++;
            if (disp_b !== mb[13:0] || es_b !== model_ovf(vals[i], 2)) begin
                errors++;
                $display("FAIL result_2dig v=%0d: disp=%b es=%b exp disp=%b es=%b",
                         vals[i], disp_b, es_b, mb[13:0], model_ovf(vals[i], 2));
            end
            @(posedge clk);
            #1;
            checks++;
            if (pr_a !== 1'b0 || oc_a !== 1'b0 || disp_a !== exp_a) begin
                errors++;
                $display("FAIL hold_result v=%0d: pr=%b oc=%b disp=%b exp pr=0 oc=0 disp=%b",
                         vals[i], pr_a, oc_a, disp_a, exp_a);
            end
        end
    endtask

    task automatic test_back_to_back;
        int seq[4] = '{31, 10, 31, 10};
        logic [34:0] ma, mb;
        @(negedge clk);
        inicio = 1'b1;
        s8     = 8'd31;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            s8 = (n % 2 == 0) ? 8'd10 : 8'd31;
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (oc_a !== 1'b1 || pr_a !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy n=%0d cyc=%0d: oc=%b pr=%b exp 1 0", n, c, oc_a, pr_a);
                end
                if (c < 7) begin
                    @(posedge clk);
                    #1;
                end
            end
            @(posedge clk);
            #1;
            ma = model_disp(seq[n], 3);
            mb = model_disp(seq[n], 2);
            checks++;
            if (pr_a !== 1'b1 || disp_a !== ma[20:0] || disp_b !== mb[13:0]) begin
                errors++;
                $display("FAIL b2b_result n=%0d: pr=%b disp_a=%b disp_b=%b exp pr=1 disp_a=%b disp_b=%b",
                         n, pr_a, disp_a, disp_b, ma[20:0], mb[13:0]);
            end
        end
        inicio = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (oc_a !== 1'b0 || pr_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: oc=%b pr=%b exp 0 0", oc_a, pr_a);
        end
    endtask

    task automatic test_ignore_inicio;
        int v = $urandom_range(0, 255);
        logic [34:0] ma;
        start_conv8(v);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (oc_a !== 1'b1 || pr_a !== 1'b0) begin
                errors++;
                $display("FAIL ignore_busy cyc=%0d: oc=%b pr=%b exp 1 0", c, oc_a, pr_a);
            end
            inicio = (c == 2 || c == 5);
            s8     = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        inicio = 1'b0;
        ma = model_disp(v, 3);
        checks++;
        if (pr_a !== 1'b1 || disp_a !== ma[20:0]) begin
            errors++;
            $display("FAIL ignore_result v=%0d: pr=%b disp=%b exp pr=1 disp=%b", v, pr_a, disp_a, ma[20:0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (oc_a !== 1'b0 || pr_a !== 1'b0) begin
            errors++;
            $display("FAIL ignore_not_queued: oc=%b pr=%b exp 0 0", oc_a, pr_a);
        end
    endtask

    task automatic test_reset_mid;
        int v = $urandom_range(0, 255);
        int pulses = 0;
        logic [34:0] ma;
        start_conv8(123);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (oc_a !== 1'b0 || pr_a !== 1'b0 || es_a !== 1'b0 || disp_a !== '1 || disp_b !== '1) begin
            errors++;
            $display("FAIL reset_mid: oc=%b pr=%b es=%b disp_a=%h disp_b=%h exp 0 0 0 all-ones",
                     oc_a, pr_a, es_a, disp_a, disp_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (pr_a !== 1'b0 || oc_a !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_pronto: active cycles=%0d exp 0", pulses);
        end
        start_conv8(v);
        repeat (8) @(posedge clk);
        #1;
        ma = model_disp(v, 3);
        checks++;
        if (pr_a !== 1'b1 || disp_a !== ma[20:0]) begin
            errors++;
            $display("FAIL reset_reconvert v=%0d: pr=%b disp=%b exp pr=1 disp=%b", v, pr_a, disp_a, ma[20:0]);
        end
    endtask

    task automatic test_wide;
        int vals[$] = '{65535, 0, 10000, 9};
        logic [34:0] mc;
        for (int i = 0; i < 4; i++) vals.push_back($urandom_range(0, 65535));
        foreach (vals[i]) begin
            @(negedge clk);
            inicio16 = 1'b1;
            s16      = 16'(vals[i]);
            @(posedge clk);
            #1;
            inicio16 = 1'b0;
            s16      = 16'($urandom_range(0, 65535));
            for (int c = 0; c < 16; c++) begin
                checks++;
                if (oc_c !== 1'b1 || pr_c !== 1'b0) begin
                    errors++;
                    $display("FAIL wide_busy v=%0d cyc=%0d: oc=%b pr=%b exp 1 0", vals[i], c, oc_c, pr_c);
                end
                @(posedge clk);
                #1;
            end
            mc = model_disp(vals[i], 5);
            checks++;
            if (pr_c !== 1'b1 || disp_c !== mc || es_c !== 1'b0) begin
                errors++;
                $display("FAIL wide_result v=%0d: pr=%b es=%b disp=%b exp pr=1 es=0 disp=%b",
                         vals[i], pr_c, es_c, disp_c, mc);
            end
        end
    endtask

    initial begin
        test_reset;
        test_conversion;
        test_back_to_back;
        test_ignore_inicio;
        test_reset_mid;
        test_wide;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
